// File: rtl/fir_pkg.sv
// Shared types and helpers for the serial-MAC FIR sequencer.
// Holds the FSM state encoding, width derivations, coefficient default and output clamp.
package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int COEF_DEFAULT = 1;

   function automatic int addr_w(input int taps);
      return (taps <= 1) ? 1 : $clog2(taps);
   endfunction

   // Wide enough that TAPS full-scale products can never wrap.
   function automatic int acc_w(input int taps, input int dw, input int cw);
      return dw + cw + $clog2(taps);
   endfunction

   function automatic logic [63:0] saturate(input logic [63:0] val, input int ow);
      logic [63:0] max_val;
      max_val = (64'd1 << ow) - 64'd1;
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// TAPS x CW coefficient register file: gated synchronous write, combinational read by tap index.
// Writes are dropped while the MAC is busy or when the address is out of range; reset restores defaults.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int TAPS = 4,
   parameter int CW   = 8,
   parameter int AW   = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic          busy,
   input  logic [AW-1:0] waddr,
   input  logic [CW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [CW-1:0] rdata
);

   localparam logic [AW:0] TAPS_L = (AW + 1)'(TAPS);

   logic [CW-1:0] coef [TAPS];
   logic          wr_en;

   assign wr_en = we && !busy && ({1'b0, waddr} < TAPS_L);
   assign rdata = coef[raddr];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) begin
            coef[i] <= CW'(COEF_DEFAULT);
         end
      end else if (wr_en) begin
         coef[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/fir_serial_ctrl.sv
// Serial-MAC FIR sequencer: one tap per cycle, result pulses TAPS+1 cycles after the accept edge.
// Accepts a sample only in IDLE (x_ready); the source holds x_in until it sees x_ready.
module fir_serial_ctrl
   import fir_pkg::*;
#(
   parameter int TAPS = 4,
   parameter int DW   = 8,
   parameter int CW   = 8,
   parameter int OW   = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DW-1:0]             x_in,
   input  logic                      x_valid,
   output logic                      x_ready,
   output logic [OW-1:0]             y_out,
   output logic                      y_valid,
   output logic                      busy,
   input  logic                      cfg_we,
   input  logic [addr_w(TAPS)-1:0]   cfg_addr,
   input  logic [CW-1:0]             cfg_data
);

   localparam int AW    = addr_w(TAPS);
   localparam int ACC_W = acc_w(TAPS, DW, CW);
   localparam int PW    = DW + CW;
   localparam logic [AW:0]   TAPS_L   = (AW + 1)'(TAPS);
   localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

   state_t             state;
   logic [DW-1:0]      slot [TAPS];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      k;
   logic [ACC_W-1:0]   acc;
   logic [AW-1:0]      rd_idx;
   logic [CW-1:0]      coef_k;
   logic [PW-1:0]      prod;

   fir_coef_bank #(
      .TAPS (TAPS),
      .CW   (CW),
      .AW   (AW)
   ) u_coef_bank (
      .clk   (clk),
      .reset (reset),
      .we    (cfg_we),
      .busy  (busy),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (k),
      .rdata (coef_k)
   );

   // Tap k reads the sample written k accepts ago; k=0 is the one just written.
   always_comb begin
      rd_idx = AW'(({1'b0, wr_ptr} >= {1'b0, k})
                   ? ({1'b0, wr_ptr} - {1'b0, k})
                   : ({1'b0, wr_ptr} + TAPS_L - {1'b0, k}));
      prod   = {{CW{1'b0}}, slot[rd_idx]} * {{DW{1'b0}}, coef_k};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         wr_ptr  <= '0;
         k       <= '0;
         acc     <= '0;
         y_out   <= '0;
         y_valid <= 1'b0;
         x_ready <= 1'b1;
         busy    <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            slot[i] <= '0;
         end
      end else begin
         y_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (x_valid) begin
                  slot[wr_ptr] <= x_in;
                  acc          <= '0;
                  k            <= '0;
                  x_ready      <= 1'b0;
                  busy         <= 1'b1;
                  state        <= ST_MAC;
               end
            end
            ST_MAC: begin
               acc <= acc + ACC_W'(prod);
               if (k == LAST_IDX) begin
                  k     <= '0;
                  state <= ST_DONE;
               end else begin
                  k <= k + AW'(1);
               end
            end
            ST_DONE: begin
               y_out   <= OW'(saturate(64'(acc), OW));
               y_valid <= 1'b1;
               wr_ptr  <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + AW'(1);
               x_ready <= 1'b1;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               state   <= ST_IDLE;
               x_ready <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
